// File: rtl/vdp18_host_master_if.sv
// Host command/response channel plus the vdp18 CPU-port pins driven by the master.
interface vdp18_host_master_if;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [0:1]  cmd_op_i;
  logic [0:13] cmd_addr_i;
  logic [0:7]  cmd_data_i;
  logic        rsp_valid_o;
  logic [0:7]  rsp_data_o;
  logic        csr_n_o;
  logic        csw_n_o;
  logic        mode_o;
  logic [0:7]  cd_o;
  logic [0:7]  cd_i;

  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cd_i,
    output cmd_ready_o, rsp_valid_o, rsp_data_o, csr_n_o, csw_n_o, mode_o, cd_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cd_i,
    input  cmd_ready_o, rsp_valid_o, rsp_data_o, csr_n_o, csw_n_o, mode_o, cd_o
  );
endinterface

// File: rtl/vdp18_host_master.sv
// Bus initiator for the vdp18 CPU port: expands host commands into strobed byte phases
// and tracks the VDP auto-increment address so sequential VRAM accesses skip setup.
//
// state    | meaning
// IDLE     | ready for a command, strobes high
// SETUP_LO | ctrl-write of low address byte (or REG_WR data byte)
// SETUP_HI | ctrl-write of high address byte + access code (or REG_WR register byte)
// DATA     | data-port write/read, or ctrl-port read for STAT_RD
module vdp18_host_master #(
  parameter int STROBE_CYC = 4,
  parameter int GAP_CYC    = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  vdp18_host_master_if.master  bus
);

  localparam int PHASE_CYC = STROBE_CYC + GAP_CYC;
  localparam int CW        = (PHASE_CYC > 2) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD    = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST_LO = CW'(GAP_CYC);

  typedef enum logic [1:0] {
    OP_REG_WR  = 2'd0,
    OP_VRAM_WR = 2'd1,
    OP_VRAM_RD = 2'd2,
    OP_STAT_RD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETUP_LO = 2'd1,
    S_SETUP_HI = 2'd2,
    S_DATA     = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  op_e           op_q;
  logic [0:13]   addr_q;
  logic [0:7]    data_q;
  logic          trk_valid_q;
  logic          trk_rd_q;
  logic [0:13]   next_addr_q;
  logic          rsp_valid_q;
  logic [0:7]    rsp_data_q;

  op_e           cmd_op;
  logic          accept;
  logic          phase_end;
  logic          strobe_lo;
  logic          last_lo;
  logic          is_read;
  logic          is_vram;
  logic          addr_hit;
  logic          mode_d;
  logic [0:7]    cd_d;

  assign cmd_op    = op_e'(bus.cmd_op_i);
  assign accept    = (state_q == S_IDLE) && bus.cmd_valid_i;
  assign phase_end = (state_q != S_IDLE) && (cnt_q == '0);
  // Counter runs PHASE_CYC-1 down to 0; the top STROBE_CYC values are the low part.
  assign strobe_lo = (state_q != S_IDLE) && (cnt_q >= CNT_LAST_LO);
  assign last_lo   = (state_q != S_IDLE) && (cnt_q == CNT_LAST_LO);
  assign is_read   = (state_q == S_DATA) && ((op_q == OP_VRAM_RD) || (op_q == OP_STAT_RD));
  assign is_vram   = (op_q == OP_VRAM_WR) || (op_q == OP_VRAM_RD);
  assign addr_hit  = trk_valid_q
                     && (trk_rd_q == (cmd_op == OP_VRAM_RD))
                     && (bus.cmd_addr_i == next_addr_q);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid_i) begin
          case (cmd_op)
            OP_REG_WR:              state_d = S_SETUP_LO;
            OP_VRAM_WR, OP_VRAM_RD: state_d = addr_hit ? S_DATA : S_SETUP_LO;
            default:                state_d = S_DATA;
          endcase
        end
      end
      S_SETUP_LO: if (phase_end) state_d = S_SETUP_HI;
      S_SETUP_HI: if (phase_end) state_d = (op_q == OP_REG_WR) ? S_IDLE : S_DATA;
      S_DATA:     if (phase_end) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mode_d = 1'b0;
    cd_d   = '0;
    case (state_q)
      S_SETUP_LO: begin
        mode_d = 1'b1;
        cd_d   = (op_q == OP_REG_WR) ? data_q : addr_q[6:13];
      end
      S_SETUP_HI: begin
        mode_d = 1'b1;
        case (op_q)
          OP_REG_WR:  cd_d = {2'b10, 3'b000, addr_q[11:13]};
          OP_VRAM_WR: cd_d = {2'b01, addr_q[0:5]};
          default:    cd_d = {2'b00, addr_q[0:5]};
        endcase
      end
      S_DATA: begin
        mode_d = (op_q == OP_STAT_RD);
        cd_d   = (op_q == OP_VRAM_WR) ? data_q : '0;
      end
      default: begin
        mode_d = 1'b0;
        cd_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if ((state_d != S_IDLE) && ((state_q == S_IDLE) || phase_end)) begin
      cnt_q <= CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q   <= OP_REG_WR;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q   <= cmd_op;
      addr_q <= bus.cmd_addr_i;
      data_q <= bus.cmd_data_i;
    end
  end

  // REG_WR clobbers the VDP address latch, so tracking is dropped as soon as one is taken.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      trk_valid_q <= 1'b0;
      trk_rd_q    <= 1'b0;
      next_addr_q <= '0;
    end else if (accept && (cmd_op == OP_REG_WR)) begin
      trk_valid_q <= 1'b0;
    end else if (phase_end && (state_q == S_DATA) && is_vram) begin
      trk_valid_q <= 1'b1;
      trk_rd_q    <= (op_q == OP_VRAM_RD);
      next_addr_q <= addr_q + 14'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= is_read && last_lo;
      if (is_read && last_lo) begin
        rsp_data_q <= bus.cd_i;
      end
    end
  end

  assign bus.cmd_ready_o = (state_q == S_IDLE);
  assign bus.csw_n_o     = ~(strobe_lo && !is_read);
  assign bus.csr_n_o     = ~(strobe_lo && is_read);
  assign bus.mode_o      = mode_d;
  assign bus.cd_o        = cd_d;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_vdp18_host_master.sv
// Bench for vdp18_host_master: command table with phase/response scoreboard, plus
// hand-written busy-ignore and mid-phase reset sequences.
module tb_vdp18_host_master;
  localparam int STROBE = 4;
  localparam int GAP    = 8;
  localparam int PH     = STROBE + GAP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vdp18_host_master_if bus_if();

  vdp18_host_master #(.STROBE_CYC(STROBE), .GAP_CYC(GAP)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus_if)
  );

  typedef struct packed {
    logic       mode;
    logic       wr;
    logic [7:0] cd;
  } ph_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [13:0] addr;
    logic [7:0]  data;
    logic [7:0]  rd;
    logic [1:0]  nph;
    logic        poke;
    ph_t         p0;
    ph_t         p1;
    ph_t         p2;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  ph_t        exp_ph[$];
  logic [7:0] exp_rsp[$];
  logic [7:0] rd_val = 8'h00;
  vec_t       tbl [14];

  // The VDP only drives the real byte while csr_n is low.
  assign bus_if.cd_i = bus_if.csr_n_o ? ~rd_val : rd_val;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic ph_t cw(input logic [7:0] b); return '{mode: 1'b1, wr: 1'b1, cd: b}; endfunction
  function automatic ph_t dw(input logic [7:0] b); return '{mode: 1'b0, wr: 1'b1, cd: b}; endfunction
  function automatic ph_t dr();                    return '{mode: 1'b0, wr: 1'b0, cd: 8'h00}; endfunction
  function automatic ph_t cr();                    return '{mode: 1'b1, wr: 1'b0, cd: 8'h00}; endfunction

  function automatic vec_t mk(input logic [1:0] op, input logic [13:0] addr, input logic [7:0] data,
                              input logic [7:0] rd, input logic [1:0] nph, input logic poke,
                              input ph_t p0, input ph_t p1, input ph_t p2);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.rd = rd; v.nph = nph; v.poke = poke;
    v.p0 = p0; v.p1 = p1; v.p2 = p2;
    return v;
  endfunction

  function automatic ph_t get_ph(input vec_t v, input int k);
    case (k)
      0:       return v.p0;
      1:       return v.p1;
      default: return v.p2;
    endcase
  endfunction

  // Bus monitor: measures each strobe, pops the scoreboard on its rising edge.
  logic       in_stb = 1'b0, have_prev = 1'b0, unstable = 1'b0, rose_rd = 1'b0;
  logic       cur_mode = 1'b0, cur_wr = 1'b0;
  logic [7:0] cur_cd = 8'h00;
  int         lo_cnt = 0, gap_cnt = 0, both_low_cnt = 0, gap_short_cnt = 0, stray_rsp_cnt = 0;
  ph_t        e;

  always @(negedge clk) begin
    rose_rd = 1'b0;
    if (rst) begin
      in_stb    = 1'b0;
      have_prev = 1'b0;
      lo_cnt    = 0;
      gap_cnt   = 0;
    end else begin
      if (!bus_if.csr_n_o && !bus_if.csw_n_o) both_low_cnt++;
      if (!bus_if.csr_n_o || !bus_if.csw_n_o) begin
        if (!in_stb) begin
          if (have_prev && gap_cnt < GAP) gap_short_cnt++;
          in_stb   = 1'b1;
          lo_cnt   = 1;
          unstable = 1'b0;
          cur_mode = bus_if.mode_o;
          cur_wr   = !bus_if.csw_n_o;
          cur_cd   = bus_if.cd_o;
        end else begin
          lo_cnt++;
          if (bus_if.mode_o !== cur_mode || bus_if.cd_o !== cur_cd || (!bus_if.csw_n_o) !== cur_wr)
            unstable = 1'b1;
        end
      end else if (in_stb) begin
        in_stb    = 1'b0;
        have_prev = 1'b1;
        gap_cnt   = 1;
        chk("strobe_width", lo_cnt, STROBE);
        chk("phase_stable", unstable, 1'b0);
        if (exp_ph.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_phase: mode=%0d wr=%0d cd=0x%02h, no phase expected", cur_mode, cur_wr, cur_cd);
        end else begin
          e = exp_ph.pop_front();
          chk("phase_mode", cur_mode, e.mode);
          chk("phase_dir", cur_wr, e.wr);
          if (e.wr) chk("phase_cd", cur_cd, e.cd);
          else      chk("rsp_timing", bus_if.rsp_valid_o, 1'b1);
          rose_rd = !cur_wr;
        end
      end else begin
        gap_cnt++;
      end

      if (bus_if.rsp_valid_o) begin
        if (!rose_rd) stray_rsp_cnt++;
        if (exp_rsp.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: data=0x%02h, no response expected", bus_if.rsp_data_o);
        end else begin
          chk("rsp_data", bus_if.rsp_data_o, exp_rsp.pop_front());
        end
      end
    end
  end

  task automatic run_cmd(input vec_t v);
    int  n;
    bit  done;
    for (int k = 0; k < int'(v.nph); k++) exp_ph.push_back(get_ph(v, k));
    if (v.op == 2'd2 || v.op == 2'd3) exp_rsp.push_back(v.rd);
    rd_val = v.rd;
    @(negedge clk);
    chk("ready_idle", bus_if.cmd_ready_o, 1'b1);
    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_op_i    = v.op;
    bus_if.cmd_addr_i  = v.addr;
    bus_if.cmd_data_i  = v.data;
    @(posedge clk);
    #1;
    // Scramble the fields so the DUT must have latched them.
    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_op_i    = ~v.op;
    bus_if.cmd_addr_i  = ~v.addr;
    bus_if.cmd_data_i  = ~v.data;
    chk("ready_drop", bus_if.cmd_ready_o, 1'b0);
    n    = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (v.poke && n == 3) begin
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_op_i    = 2'd0;
      end
      if (v.poke && n == 8) bus_if.cmd_valid_i = 1'b0;
      if (bus_if.cmd_ready_o) done = 1'b1;
    end
    chk("busy_cycles", n, int'(v.nph) * PH);
    repeat (2) @(negedge clk);
    chk("phases_drained", exp_ph.size(), 0);
    chk("rsp_drained", exp_rsp.size(), 0);
    exp_ph.delete();
    exp_rsp.delete();
  endtask

  initial begin
    int n;
    tbl[0]  = mk(2'd0, 14'h0007, 8'hF4, 8'h00, 2'd2, 1'b0, cw(8'hF4), cw(8'h87), dr());
    tbl[1]  = mk(2'd1, 14'h1800, 8'h55, 8'h00, 2'd3, 1'b0, cw(8'h00), cw(8'h58), dw(8'h55));
    tbl[2]  = mk(2'd1, 14'h1801, 8'hAA, 8'h00, 2'd1, 1'b0, dw(8'hAA), dr(), dr());
    tbl[3]  = mk(2'd2, 14'h3FFF, 8'h00, 8'h3C, 2'd3, 1'b0, cw(8'hFF), cw(8'h3F), dr());
    tbl[4]  = mk(2'd2, 14'h0000, 8'h00, 8'hC3, 2'd1, 1'b0, dr(), dr(), dr());
    tbl[5]  = mk(2'd1, 14'h0100, 8'h11, 8'h00, 2'd3, 1'b0, cw(8'h00), cw(8'h41), dw(8'h11));
    tbl[6]  = mk(2'd3, 14'h0000, 8'h00, 8'h9F, 2'd1, 1'b0, cr(), dr(), dr());
    tbl[7]  = mk(2'd1, 14'h0101, 8'h22, 8'h00, 2'd1, 1'b0, dw(8'h22), dr(), dr());
    tbl[8]  = mk(2'd1, 14'h0200, 8'h33, 8'h00, 2'd3, 1'b0, cw(8'h00), cw(8'h42), dw(8'h33));
    tbl[9]  = mk(2'd0, 14'h0001, 8'h0F, 8'h00, 2'd2, 1'b0, cw(8'h0F), cw(8'h81), dr());
    tbl[10] = mk(2'd1, 14'h0201, 8'h44, 8'h00, 2'd3, 1'b0, cw(8'h01), cw(8'h42), dw(8'h44));
    tbl[11] = mk(2'd2, 14'h0202, 8'h00, 8'h5A, 2'd3, 1'b0, cw(8'h02), cw(8'h02), dr());
    tbl[12] = mk(2'd1, 14'h0202, 8'h66, 8'h00, 2'd3, 1'b0, cw(8'h02), cw(8'h42), dw(8'h66));
    tbl[13] = mk(2'd1, 14'h0203, 8'h99, 8'h00, 2'd1, 1'b1, dw(8'h99), dr(), dr());

    bus_if.cmd_valid_i = 1'b0;
    bus_if.cmd_op_i    = 2'd0;
    bus_if.cmd_addr_i  = 14'h0000;
    bus_if.cmd_data_i  = 8'h00;

    #1;
    chk("rst_csr_n", bus_if.csr_n_o, 1'b1);
    chk("rst_csw_n", bus_if.csw_n_o, 1'b1);
    chk("rst_mode", bus_if.mode_o, 1'b0);
    chk("rst_cd", bus_if.cd_o, 8'h00);
    chk("rst_rsp_valid", bus_if.rsp_valid_o, 1'b0);
    chk("rst_rsp_data", bus_if.rsp_data_o, 8'h00);
    chk("rst_ready", bus_if.cmd_ready_o, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_first_cycle", bus_if.cmd_ready_o, 1'b1);

    for (int i = 0; i < 14; i++) run_cmd(tbl[i]);

    // Mid-phase reset: tracking says 0x0204 is next, so this write is data-only.
    rd_val = 8'h00;
    @(negedge clk);
    bus_if.cmd_valid_i = 1'b1;
    bus_if.cmd_op_i    = 2'd1;
    bus_if.cmd_addr_i  = 14'h0204;
    bus_if.cmd_data_i  = 8'h77;
    @(posedge clk);
    #1;
    bus_if.cmd_valid_i = 1'b0;
    n = 0;
    while (bus_if.csw_n_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("abort_strobe_start", n, 0);
    chk("abort_is_data_phase", bus_if.mode_o, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("reset_csw_n", bus_if.csw_n_o, 1'b1);
    chk("reset_csr_n", bus_if.csr_n_o, 1'b1);
    chk("reset_ready", bus_if.cmd_ready_o, 1'b1);
    chk("reset_rsp_data", bus_if.rsp_data_o, 8'h00);
    chk("reset_cd", bus_if.cd_o, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_release", bus_if.cmd_ready_o, 1'b1);
    chk("csw_after_release", bus_if.csw_n_o, 1'b1);
    run_cmd(mk(2'd1, 14'h0204, 8'h88, 8'h00, 2'd3, 1'b0, cw(8'h04), cw(8'h42), dw(8'h88)));

    chk("both_strobes_low_cycles", both_low_cnt, 0);
    chk("short_gaps", gap_short_cnt, 0);
    chk("stray_rsp_pulses", stray_rsp_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
